// File: rtl/gdmux_pkg.sv
// rtl/gdmux_pkg.sv - shared constants and helpers for the streaming demux
package gdmux_pkg;

    localparam int GDMUX_WIDTH = 16;
    localparam int GDMUX_NWAY  = 8;
    localparam int GDMUX_CNTW  = 16;

    function automatic int chan_slice(input int k, input int w = GDMUX_WIDTH);
        return k * w;
    endfunction

endpackage

// File: rtl/gdmux_slot.sv
// rtl/gdmux_slot.sv - single-entry output holding register with load/drain
module gdmux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // A load wins over a same-cycle drain so the channel streams at full rate.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign free  = !valid_q || drain;
    assign valid = valid_q;
    assign data  = valid_q ? data_q : '0;

endmodule

// File: rtl/gdmux_stream.sv
// rtl/gdmux_stream.sv - registered 1-to-NWAY stream demux with broadcast
module gdmux_stream
    import gdmux_pkg::*;
#(
    parameter int WIDTH = GDMUX_WIDTH,
    parameter int NWAY  = GDMUX_NWAY,
    parameter int SELW  = $clog2(NWAY),
    parameter int CNTW  = GDMUX_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      d,
    input  logic [SELW-1:0]       sel,
    input  logic                  bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NWAY*WIDTH-1:0] y,
    output logic [NWAY-1:0]       y_valid,
    input  logic [NWAY-1:0]       y_ready,
    output logic [CNTW-1:0]       beat_cnt
);

    logic [NWAY-1:0] free;
    logic [NWAY-1:0] target;
    logic [NWAY-1:0] load;
    logic            accept;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    // Broadcast is all-or-nothing: it waits until every slot can take the word.
    always_comb begin
        target = '0;
        if (bcast) begin
            target = '1;
        end else begin
            target[sel] = 1'b1;
        end
        in_ready   = bcast ? &free : free[sel];
        accept     = in_valid && in_ready;
        load       = accept ? target : '0;
        beat_cnt_d = accept ? beat_cnt_q + CNTW'(1) : beat_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

    for (genvar k = 0; k < NWAY; k++) begin : g_slot
        gdmux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (d),
            .drain     (y_ready[k]),
            .data      (y[chan_slice(k, WIDTH) +: WIDTH]),
            .valid     (y_valid[k]),
            .free      (free[k])
        );
    end

endmodule

// File: tb/tb_gdmux_stream.sv
// tb/tb_gdmux_stream.sv - table-driven bench for gdmux_stream
module tb_gdmux_stream;

    localparam int W = 16;
    localparam int N = 8;
    localparam int S = 3;
    localparam int C = 4;
    localparam int NROWS = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   d;
    logic [S-1:0]   sel;
    logic           bcast;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] y;
    logic [N-1:0]   y_valid;
    logic [N-1:0]   y_ready;
    logic [C-1:0]   beat_cnt;

    always #5 clk = ~clk;

    gdmux_stream #(.WIDTH(W), .NWAY(N), .CNTW(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .sel      (sel),
        .bcast    (bcast),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .beat_cnt (beat_cnt)
    );

    typedef struct {
        logic         iv;
        logic [S-1:0] sel;
        logic         bc;
        logic [W-1:0] d;
        logic [N-1:0] yr;
        logic         rdy;
        logic [N-1:0] yv;
        logic [C-1:0] cnt;
        int           ch;
        logic [W-1:0] cd;
        logic         all_eq;
    } vec_t;

    vec_t tbl [NROWS];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slice(input int k);
        return y[k*W +: W];
    endfunction

    function automatic vec_t mk(input logic iv, input logic [S-1:0] s, input logic bc,
                                input logic [W-1:0] dd, input logic [N-1:0] yr,
                                input logic rdy, input logic [N-1:0] yv, input logic [C-1:0] cnt,
                                input int ch, input logic [W-1:0] cd, input logic all_eq);
        vec_t v;
        v.iv = iv; v.sel = s; v.bc = bc; v.d = dd; v.yr = yr;
        v.rdy = rdy; v.yv = yv; v.cnt = cnt; v.ch = ch; v.cd = cd; v.all_eq = all_eq;
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] idle_lanes;

        rst_n = 1'b0; in_valid = 1'b0; sel = '0; bcast = 1'b0; d = '0; y_ready = '1;

        tbl[0]  = mk(1, 3, 0, 16'hBEEF, 8'hFF, 1, 8'h08, 4'd1, 3, 16'hBEEF, 0);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 8'hFF, 1, 8'h00, 4'd1, 3, 16'h0000, 0);
        tbl[2]  = mk(1, 5, 0, 16'h1111, 8'hDF, 1, 8'h20, 4'd2, 5, 16'h1111, 0);
        tbl[3]  = mk(1, 5, 0, 16'h2222, 8'hDF, 0, 8'h20, 4'd2, 5, 16'h1111, 0);
        tbl[4]  = mk(1, 5, 0, 16'h2222, 8'hFF, 1, 8'h20, 4'd3, 5, 16'h2222, 0);
        tbl[5]  = mk(0, 5, 0, 16'h0000, 8'hFF, 1, 8'h00, 4'd3, 5, 16'h0000, 0);
        for (int i = 0; i < 8; i++)
            tbl[6+i] = mk(1, 0, 0, W'(16'hA000 + i), 8'hFF, 1, 8'h01, C'(4 + i), 0, W'(16'hA000 + i), 0);
        tbl[14] = mk(0, 0, 0, 16'h0000, 8'hFF, 1, 8'h00, 4'd11, 0, 16'h0000, 0);
        tbl[15] = mk(1, 2, 0, 16'h5555, 8'hFB, 1, 8'h04, 4'd12, 2, 16'h5555, 0);
        tbl[16] = mk(1, 0, 1, 16'h1234, 8'hFB, 0, 8'h04, 4'd12, 0, 16'h0000, 0);
        tbl[17] = mk(1, 0, 1, 16'h1234, 8'hFF, 1, 8'hFF, 4'd13, 2, 16'h1234, 1);
        tbl[18] = mk(0, 0, 0, 16'h0000, 8'h00, 0, 8'hFF, 4'd13, 7, 16'h1234, 1);
        tbl[19] = mk(0, 0, 0, 16'h0000, 8'hFF, 1, 8'h00, 4'd13, 0, 16'h0000, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset y_valid", 128'(y_valid), 128'(0));
        chk("reset y", 128'(y), 128'(0));
        chk("reset beat_cnt", 128'(beat_cnt), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; sel = tbl[i].sel; bcast = tbl[i].bc;
            d = tbl[i].d; y_ready = tbl[i].yr;
            #1;
            chk($sformatf("row%0d in_ready", i), 128'(in_ready), 128'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d y_valid", i), 128'(y_valid), 128'(tbl[i].yv));
            chk($sformatf("row%0d beat_cnt", i), 128'(beat_cnt), 128'(tbl[i].cnt));
            chk($sformatf("row%0d y[ch%0d]", i, tbl[i].ch), 128'(slice(tbl[i].ch)), 128'(tbl[i].cd));
            idle_lanes = '0;
            for (int k = 0; k < N; k++)
                if (!tbl[i].yv[k]) idle_lanes[k*W +: W] = slice(k);
            chk($sformatf("row%0d idle lanes zero", i), 128'(idle_lanes), 128'(0));
            if (tbl[i].all_eq)
                for (int k = 0; k < N; k++)
                    chk($sformatf("row%0d bcast y[ch%0d]", i, k), 128'(slice(k)), 128'(tbl[i].cd));
        end

        // Fill channels 0 and 7 with stalled consumers, then assert reset between edges.
        @(negedge clk);
        in_valid = 1'b1; bcast = 1'b0; sel = 3'd0; d = 16'hAAAA; y_ready = 8'h7E;
        #1;
        chk("areset load0 in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        sel = 3'd7; d = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("areset pre y_valid", 128'(y_valid), 128'(8'h81));
        chk("areset pre y[ch0]", 128'(slice(0)), 128'(16'hAAAA));
        chk("areset pre y[ch7]", 128'(slice(7)), 128'(16'h7777));
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset y_valid", 128'(y_valid), 128'(0));
        chk("areset y", 128'(y), 128'(0));
        chk("areset beat_cnt", 128'(beat_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1; y_ready = '1;

        // Counter wrap: 17 accepts on a 4-bit counter.
        in_valid = 1'b1; sel = 3'd1;
        for (int i = 0; i < 17; i++) begin
            d = W'(i);
            #1;
            chk($sformatf("wrap beat%0d in_ready", i), 128'(in_ready), 128'(1));
            @(posedge clk);
            #1;
            if (i == 15) chk("wrap beat_cnt at 16", 128'(beat_cnt), 128'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("wrap beat_cnt at 17", 128'(beat_cnt), 128'(1));
        chk("wrap y[ch1]", 128'(slice(1)), 128'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
